// File: rtl/parametrik_cift_port_ram_if.sv
// Write and read port bundle for parametrik_cift_port_ram.
// The master side drives write/read requests; the slave side (the RAM)
// returns read data, its valid flag, the ready flag and the error pulse.
interface parametrik_cift_port_ram_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                      yaz_en;
    logic [ADDR_WIDTH-1:0]     yaz_addr;
    logic [DATA_WIDTH-1:0]     yaz_data;
    logic [DATA_WIDTH/8-1:0]   yaz_be;
    logic                      oku_en;
    logic [ADDR_WIDTH-1:0]     oku_addr;
    logic [DATA_WIDTH-1:0]     oku_data;
    logic                      oku_gecerli;
    logic                      hazir;
    logic                      hata;

    modport master (
        output yaz_en, yaz_addr, yaz_data, yaz_be, oku_en, oku_addr,
        input  oku_data, oku_gecerli, hazir, hata
    );

    modport slave (
        input  yaz_en, yaz_addr, yaz_data, yaz_be, oku_en, oku_addr,
        output oku_data, oku_gecerli, hazir, hata
    );
endinterface

// File: rtl/parametrik_cift_port_ram.sv
// Single-clock dual-port RAM: one write port with byte enables, one read
// port with a valid-qualified output and a selectable latency of 1 or 2.
// After reset the memory is optionally zeroed one word per cycle before
// the ports start accepting requests.
module parametrik_cift_port_ram #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 16,
    parameter int OUT_REG        = 0,
    parameter int RW_MODE        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic                     clk,
    input logic                     rst,
    parametrik_cift_port_ram_if.slave bus
);

    localparam int                  BE_W    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] SON_ADR = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {
        TEMIZLE,
        HAZIR
    } durum_t;

    durum_t                  durum;
    durum_t                  sonraki_durum;
    logic [ADDR_WIDTH:0]     cnt;
    logic [ADDR_WIDTH:0]     sonraki_cnt;
    logic                    hazir_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    yaz_aralikta;
    logic                    oku_aralikta;
    logic                    yaz_kabul;
    logic                    oku_kabul;
    logic                    hatali;
    logic [DATA_WIDTH-1:0]   eski_kelime;
    logic [DATA_WIDTH-1:0]   birlesik;
    logic [DATA_WIDTH-1:0]   oku_kelime;

    logic                    a_v;
    logic [DATA_WIDTH-1:0]   a_d;
    logic                    a_hata;
    logic                    b_v;
    logic [DATA_WIDTH-1:0]   b_d;
    logic                    cikis_v;
    logic [DATA_WIDTH-1:0]   cikis_d;
    logic                    oku_gecerli_q;
    logic [DATA_WIDTH-1:0]   oku_data_q;
    logic                    hata_q;

    // Request qualification: only a ready RAM accepts, addresses past DEPTH are flagged
    always_comb begin
        yaz_aralikta = ({1'b0, bus.yaz_addr} < DEPTH_W);
        oku_aralikta = ({1'b0, bus.oku_addr} < DEPTH_W);
        yaz_kabul    = hazir_q && bus.yaz_en && yaz_aralikta;
        oku_kabul    = hazir_q && bus.oku_en;
        hatali       = hazir_q && ((bus.yaz_en && !yaz_aralikta) ||
                                   (bus.oku_en && !oku_aralikta));
    end

    // Merge the write data into the stored word lane by lane
    always_comb begin
        eski_kelime = mem[bus.yaz_addr];
        birlesik    = eski_kelime;
        for (int i = 0; i < BE_W; i++) begin
            if (bus.yaz_be[i]) begin
                birlesik[8*i +: 8] = bus.yaz_data[8*i +: 8];
            end
        end
    end

    // Read word selection: zero when out of range, bypass the merged word in write-first mode
    always_comb begin
        oku_kelime = '0;
        if (oku_aralikta) begin
            if ((RW_MODE != 0) && yaz_kabul && (bus.yaz_addr == bus.oku_addr)) begin
                oku_kelime = birlesik;
            end else begin
                oku_kelime = mem[bus.oku_addr];
            end
        end
    end

    // Clear/ready state register with the clear counter
    always_ff @(posedge clk) begin
        if (rst) begin
            durum   <= (CLEAR_ON_RESET != 0) ? TEMIZLE : HAZIR;
            cnt     <= '0;
            hazir_q <= 1'b0;
        end else begin
            durum   <= sonraki_durum;
            cnt     <= sonraki_cnt;
            hazir_q <= (sonraki_durum == HAZIR);
        end
    end

    // Next state: step through every word while clearing, then stay ready
    always_comb begin
        sonraki_durum = durum;
        sonraki_cnt   = cnt;
        case (durum)
            TEMIZLE: begin
                if (cnt == SON_ADR) begin
                    sonraki_durum = HAZIR;
                end else begin
                    sonraki_cnt = cnt + (ADDR_WIDTH + 1)'(1);
                end
            end
            HAZIR: begin
                sonraki_durum = HAZIR;
            end
            default: begin
                sonraki_durum = HAZIR;
            end
        endcase
    end

    // Memory array: clear writes while clearing, byte-merged user writes once ready
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (durum == TEMIZLE) begin
                mem[cnt[ADDR_WIDTH-1:0]] <= '0;
            end else if (yaz_kabul) begin
                mem[bus.yaz_addr] <= birlesik;
            end
        end
    end

    // Read pipeline: capture stage, optional extra stage, then the held output register
    always_ff @(posedge clk) begin
        if (rst) begin
            a_v           <= 1'b0;
            a_d           <= '0;
            a_hata        <= 1'b0;
            b_v           <= 1'b0;
            b_d           <= '0;
            oku_gecerli_q <= 1'b0;
            oku_data_q    <= '0;
            hata_q        <= 1'b0;
        end else begin
            a_v    <= oku_kabul;
            a_hata <= hatali;
            if (oku_kabul) begin
                a_d <= oku_kelime;
            end
            b_v <= a_v;
            if (a_v) begin
                b_d <= a_d;
            end
            oku_gecerli_q <= cikis_v;
            if (cikis_v) begin
                oku_data_q <= cikis_d;
            end
            hata_q <= a_hata;
        end
    end

    // Pick which pipeline stage feeds the output register
    always_comb begin
        cikis_v = (OUT_REG != 0) ? b_v : a_v;
        cikis_d = (OUT_REG != 0) ? b_d : a_d;
    end

    assign bus.oku_data    = oku_data_q;
    assign bus.oku_gecerli = oku_gecerli_q;
    assign bus.hazir       = hazir_q;
    assign bus.hata        = hata_q;

endmodule

// File: tb/tb_parametrik_cift_port_ram.sv
// Bench for parametrik_cift_port_ram: two instances (DEPTH 16 / latency 1 /
// old-data and DEPTH 12 / latency 2 / write-first) share one stimulus stream
// and are compared every cycle against a word-array reference model.
module tb_parametrik_cift_port_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        yaz_en;
    logic [3:0]  yaz_addr;
    logic [15:0] yaz_data;
    logic [1:0]  yaz_be;
    logic        oku_en;
    logic [3:0]  oku_addr;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parametrik_cift_port_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus_a ();
    parametrik_cift_port_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus_b ();

    assign bus_a.yaz_en   = yaz_en;
    assign bus_a.yaz_addr = yaz_addr;
    assign bus_a.yaz_data = yaz_data;
    assign bus_a.yaz_be   = yaz_be;
    assign bus_a.oku_en   = oku_en;
    assign bus_a.oku_addr = oku_addr;
    assign bus_b.yaz_en   = yaz_en;
    assign bus_b.yaz_addr = yaz_addr;
    assign bus_b.yaz_data = yaz_data;
    assign bus_b.yaz_be   = yaz_be;
    assign bus_b.oku_en   = oku_en;
    assign bus_b.oku_addr = oku_addr;

    parametrik_cift_port_ram #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(16),
        .OUT_REG(0), .RW_MODE(0), .CLEAR_ON_RESET(1)
    ) u_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    parametrik_cift_port_ram #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(12),
        .OUT_REG(1), .RW_MODE(1), .CLEAR_ON_RESET(1)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Reference model state, one slot per instance
    int  derinlik [2] = '{16, 12};
    int  gecikme  [2] = '{1, 2};
    bit  yeni_veri[2] = '{1'b0, 1'b1};

    logic [15:0] m_mem [2][16];
    int          m_k   [2];
    bit          m_hz  [2];
    bit          m_hata_bek [2];
    bit          m_hata[2];
    bit          m_vld [2];
    logic [15:0] m_dat [2];

    typedef struct {
        int          inst;
        int          due;
        logic [15:0] d;
    } okuma_t;
    okuma_t bekleyen[$];

    function automatic logic [15:0] yamala(input logic [15:0] eski, input logic [15:0] yeni,
                                           input logic [1:0] be);
        logic [15:0] r;
        r = eski;
        if (be[0]) r[7:0]  = yeni[7:0];
        if (be[1]) r[15:8] = yeni[15:8];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit we, input logic [3:0] wa, input logic [15:0] wd,
                                 input logic [1:0] wb, input bit re, input logic [3:0] ra);
        yaz_en   = we;
        yaz_addr = wa;
        yaz_data = wd;
        yaz_be   = wb;
        oku_en   = re;
        oku_addr = ra;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0);
    endtask

    // One clock: advance the model with the sampled inputs, then compare both instances
    task automatic cycle();
        bit          r_s, we_s, re_s, kabul, bulundu;
        logic [3:0]  wa_s, ra_s;
        logic [15:0] wd_s, sonuc;
        logic [1:0]  wb_s;
        @(posedge clk);
        r_s  = rst;
        we_s = yaz_en;
        wa_s = yaz_addr;
        wd_s = yaz_data;
        wb_s = yaz_be;
        re_s = oku_en;
        ra_s = oku_addr;
        for (int p = 0; p < 2; p++) begin
            if (r_s) begin
                m_k[p]        = 0;
                m_hz[p]       = 1'b0;
                m_hata_bek[p] = 1'b0;
                m_hata[p]     = 1'b0;
                m_vld[p]      = 1'b0;
                m_dat[p]      = 16'h0000;
                for (int i = bekleyen.size() - 1; i >= 0; i--) begin
                    if (bekleyen[i].inst == p) bekleyen.delete(i);
                end
            end else begin
                kabul  = m_hz[p];
                m_k[p] = m_k[p] + 1;
                m_hata[p]     = m_hata_bek[p];
                m_hata_bek[p] = kabul && ((we_s && int'(wa_s) >= derinlik[p]) ||
                                          (re_s && int'(ra_s) >= derinlik[p]));
                m_vld[p] = 1'b0;
                bulundu  = 1'b0;
                for (int i = 0; i < bekleyen.size() && !bulundu; i++) begin
                    if (bekleyen[i].inst == p && bekleyen[i].due == m_k[p]) begin
                        m_vld[p] = 1'b1;
                        m_dat[p] = bekleyen[i].d;
                        bekleyen.delete(i);
                        bulundu = 1'b1;
                    end
                end
                if (kabul && re_s) begin
                    if (int'(ra_s) >= derinlik[p]) begin
                        sonuc = 16'h0000;
                    end else begin
                        sonuc = m_mem[p][ra_s];
                        if (yeni_veri[p] && we_s && wa_s == ra_s)
                            sonuc = yamala(sonuc, wd_s, wb_s);
                    end
                    bekleyen.push_back('{p, m_k[p] + gecikme[p], sonuc});
                end
                if (kabul && we_s && int'(wa_s) < derinlik[p]) begin
                    m_mem[p][wa_s] = yamala(m_mem[p][wa_s], wd_s, wb_s);
                end
                if (!m_hz[p] && m_k[p] >= derinlik[p]) begin
                    for (int w = 0; w < 16; w++) m_mem[p][w] = 16'h0000;
                    m_hz[p] = 1'b1;
                end
            end
        end
        #1;
        checkOutput("a_gecerli", 32'(bus_a.oku_gecerli), 32'(m_vld[0]));
        checkOutput("a_data",    32'(bus_a.oku_data),    32'(m_dat[0]));
        checkOutput("a_hata",    32'(bus_a.hata),        32'(m_hata[0]));
        checkOutput("a_hazir",   32'(bus_a.hazir),       32'(m_hz[0]));
        checkOutput("b_gecerli", 32'(bus_b.oku_gecerli), 32'(m_vld[1]));
        checkOutput("b_data",    32'(bus_b.oku_data),    32'(m_dat[1]));
        checkOutput("b_hata",    32'(bus_b.hata),        32'(m_hata[1]));
        checkOutput("b_hazir",   32'(bus_b.hazir),       32'(m_hz[1]));
    endtask

    // Directed sequence followed by a random phase
    initial begin
        int rdy_a, rdy_b, sayac;
        rst = 1'b1;
        idle();
        cycle();
        cycle();
        checkOutput("reset_hazir", 32'(bus_a.hazir), 32'd0);
        checkOutput("reset_data",  32'(bus_a.oku_data), 32'd0);
        rst = 1'b0;

        // Clearing: requests are ignored, ready rises after DEPTH edges
        rdy_a = 0;
        rdy_b = 0;
        sayac = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i <= 8) applyStimulus(1'b1, 4'(i), 16'hFFFF, 2'b11, 1'b1, 4'(i + 6));
            else        idle();
            cycle();
            if (i <= 10) sayac += int'(bus_a.oku_gecerli) + int'(bus_a.hata) +
                                  int'(bus_b.oku_gecerli) + int'(bus_b.hata);
            if (bus_a.hazir && rdy_a == 0) rdy_a = i;
            if (bus_b.hazir && rdy_b == 0) rdy_b = i;
        end
        checkOutput("clear_ignored", 32'(sayac), 32'd0);
        checkOutput("ready_a_16", 32'(rdy_a), 32'd16);
        checkOutput("ready_b_12", 32'(rdy_b), 32'd12);

        // Every word reads back as zero
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'(i));
            cycle();
        end
        idle();
        repeat (3) cycle();

        // Byte-enabled update then read latency
        applyStimulus(1'b1, 4'd3, 16'hA5C3, 2'b11, 1'b0, 4'd0);
        cycle();
        applyStimulus(1'b1, 4'd3, 16'h1200, 2'b10, 1'b0, 4'd0);
        cycle();
        applyStimulus(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3);
        cycle();
        idle();
        cycle();
        checkOutput("t2_a_data", 32'(bus_a.oku_data), 32'h12C3);
        checkOutput("t2_a_vld",  32'(bus_a.oku_gecerli), 32'd1);
        checkOutput("t2_b_early", 32'(bus_b.oku_gecerli), 32'd0);
        cycle();
        checkOutput("t2_b_data", 32'(bus_b.oku_data), 32'h12C3);
        checkOutput("t2_b_vld",  32'(bus_b.oku_gecerli), 32'd1);

        // Same-address read during write
        applyStimulus(1'b1, 4'd5, 16'h1111, 2'b11, 1'b0, 4'd0);
        cycle();
        applyStimulus(1'b1, 4'd5, 16'h2222, 2'b11, 1'b1, 4'd5);
        cycle();
        applyStimulus(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5);
        cycle();
        checkOutput("t3_a_old", 32'(bus_a.oku_data), 32'h1111);
        idle();
        cycle();
        checkOutput("t3_b_new", 32'(bus_b.oku_data), 32'h2222);
        checkOutput("t3_a_next", 32'(bus_a.oku_data), 32'h2222);
        cycle();
        checkOutput("t3_b_next", 32'(bus_b.oku_data), 32'h2222);

        // Out-of-range write and read together on the 12-word instance
        applyStimulus(1'b1, 4'd14, 16'hBEEF, 2'b11, 1'b1, 4'd14);
        cycle();
        idle();
        cycle();
        checkOutput("t4_b_hata", 32'(bus_b.hata), 32'd1);
        checkOutput("t4_a_hata", 32'(bus_a.hata), 32'd0);
        cycle();
        checkOutput("t4_b_hata_end", 32'(bus_b.hata), 32'd0);
        checkOutput("t4_b_vld",  32'(bus_b.oku_gecerli), 32'd1);
        checkOutput("t4_b_zero", 32'(bus_b.oku_data), 32'd0);
        repeat (2) cycle();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom),
                          2'($urandom), 1'($urandom_range(0, 1)), 4'($urandom));
            cycle();
        end
        idle();
        repeat (3) cycle();

        // Reset while a read is in flight: no stray valid
        applyStimulus(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3);
        cycle();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sayac = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            sayac += int'(bus_a.oku_gecerli) + int'(bus_b.oku_gecerli);
        end
        checkOutput("t5_no_stray", 32'(sayac), 32'd0);

        // Reset mid-clear restarts the full clear
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        rdy_a = 0;
        rdy_b = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (bus_a.hazir && rdy_a == 0) rdy_a = i;
            if (bus_b.hazir && rdy_b == 0) rdy_b = i;
        end
        checkOutput("t5_ready_a", 32'(rdy_a), 32'd16);
        checkOutput("t5_ready_b", 32'(rdy_b), 32'd12);

        // Memory re-cleared by the reset taken in the ready state
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'(i));
            cycle();
        end
        idle();
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
